// File: rtl/d_flip_flop.sv
// Positive-edge D flip-flop with true/complement outputs and synchronous
// active-low reset. Generic registered bit / small bus primitive.
//
// Optional build macro D_FLIP_FLOP_CHECK_EN compiles in simulation-only
// checkers (X/Z on inputs at a clock edge, qbar/q consistency, WIDTH sanity).
// Ports and register behaviour are identical with or without the macro.
module d_flip_flop #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic [WIDTH-1:0] d,
  input  logic             reset
);

  logic [WIDTH-1:0] q_q;

  // State register: reset (active low) is sampled only at the rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= d;
    end
  end

  // Outputs come straight from the register; qbar is an inverter, not a second flop,
  // so q and qbar can never disagree.
  always_comb begin
    q    = q_q;
    qbar = ~q_q;
  end

`ifdef D_FLIP_FLOP_CHECK_EN
`ifndef SYNTHESIS
  // Before the first edge q is legitimately unknown, so checks start after it.
  logic seen_edge;

  initial begin
    seen_edge = 1'b0;
    if (WIDTH < 1) begin
      $error("d_flip_flop: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
  end

  // Flag unknown inputs at any sampling edge after the first.
  always @(posedge clk) begin
    if (seen_edge && ($isunknown(d) || $isunknown(reset))) begin
      $error("d_flip_flop: X/Z on d (%b) or reset (%b) at rising clk", d, reset);
    end
    seen_edge <= 1'b1;
  end

  // Complement output must track the register at all times.
  always @(q or qbar or seen_edge) begin
    if (seen_edge && (qbar !== ~q)) begin
      $error("d_flip_flop: qbar (%b) is not ~q (%b)", qbar, q);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: a WIDTH=1 instance and a WIDTH=8 /
// RESET_VALUE=8'hA5 instance driven side by side. The driver pushes the
// hand-computed post-edge value for each step; the monitor pops and compares
// shortly after every rising edge.
module tb_d_flip_flop;

  logic       clk;
  logic       q1, qbar1, d1, r1;
  logic [7:0] q8, qbar8, d8;
  logic       r8;

  d_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk  (clk),
    .q    (q1),
    .qbar (qbar1),
    .d    (d1),
    .reset(r1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk  (clk),
    .q    (q8),
    .qbar (qbar8),
    .d    (d8),
    .reset(r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       e1;
    logic [7:0] e8;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge presents a new registered value.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".q1"},    {7'b0, q1},    {7'b0, e.e1});
      check({e.tag, ".qbar1"}, {7'b0, qbar1}, {7'b0, ~e.e1});
      check({e.tag, ".q8"},    q8,            e.e8);
      check({e.tag, ".qbar8"}, qbar8,         ~e.e8);
    end
  end

  logic       have_prev = 1'b0;
  logic       prev1;
  logic [7:0] prev8;

  // One cycle of stimulus, applied at the falling edge. Optional glitches on d or
  // reset happen entirely between edges. Just before the edge, q must still hold
  // the previous step's value.
  task automatic step(input string tag, input logic nd1, input logic nr1,
                      input logic [7:0] nd8, input logic nr8,
                      input bit pulse_d, input bit pulse_r,
                      input logic e1, input logic [7:0] e8);
    exp_t e;
    @(negedge clk);
    d1 = nd1; r1 = nr1; d8 = nd8; r8 = nr8;
    if (pulse_d) begin
      #1 d1 = ~nd1; d8 = ~nd8;
      #1 d1 = nd1;  d8 = nd8;
    end
    if (pulse_r) begin
      #1 r1 = ~nr1; r8 = ~nr8;
      #1 r1 = nr1;  r8 = nr8;
    end
    if (have_prev) begin
      #1;
      check({tag, ".hold1"}, {7'b0, q1}, {7'b0, prev1});
      check({tag, ".hold8"}, q8, prev8);
    end
    e.e1 = e1; e.e8 = e8; e.tag = tag;
    sb.push_back(e);
    prev1 = e1; prev8 = e8; have_prev = 1'b1;
  endtask

  initial begin
    d1 = 1'b1; r1 = 1'b0; d8 = 8'hFF; r8 = 1'b0;

    // Reset at the first edge: d ignored.
    step("rst0", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);

    // Free-run toggle: d starts 0 and inverts every edge; q follows.
    for (int i = 0; i < 20; i++) begin
      step("run", i[0], 1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, i[0], 8'h10 + 8'(i));
    end

    // Sync reset with d=1 for 3 edges; hold check shows no change before the edge.
    for (int i = 0; i < 3; i++) begin
      step("srst", 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    end

    // Release with d=1: loads at the next edge, not before.
    step("rel", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);

    // Load 0, then a 0->1->0 d glitch between edges must not disturb q.
    step("ld0", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("dglt", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // A reset glitch well clear of the edge is ignored; d loads.
    step("rglt", 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);

    // Reset mid-stream discards data.
    step("mrst", 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    step("wide", 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #5;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
